com_ram_stream_reader: RTL

- Read-side client for a synchronous single- or dual-port RAM port: en/addr out, registered dout in, one-cycle read latency, dout holds when en is low.
- Accepts a command (base address, length) and streams that many consecutive words onto a valid/ready output with a last flag.
- Fully throughput-matched under backpressure.
- Sits between feature/weight buffers and compute or DMA-out stages.

---
 rtl/com_ram_stream_reader_pkg.sv | 18 +
 rtl/com_sync_fifo2.sv | 51 +++++
 rtl/com_ram_stream_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/com_ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader family: FSM encoding,
// RAM read latency and the depth of the output skid FIFO.
package com_ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Cycles between ram_en and valid ram_dout.
    localparam int READ_LATENCY = 1;

    // Entries in the output FIFO that absorbs in-flight reads under backpressure.
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/com_sync_fifo2.sv
// Two-entry first-word-fall-through FIFO. The head entry is visible on dout
// whenever count is non-zero. Push and pop together while full is legal.
module com_sync_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    // Qualify requests so the FIFO can never overflow or underflow.
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/com_ram_stream_reader.sv
// Reads cmd_len consecutive words starting at cmd_base from a RAM port with
// one-cycle registered read latency and streams them on a valid/ready output.
// Reads are issued only while an output slot is guaranteed, so the stream
// runs at one beat per cycle when m_ready is held high.
module com_ram_stream_reader
    import com_ram_stream_reader_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDR_BIT = 10,
    parameter int LEN_BIT  = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_BIT-1:0] cmd_base,
    input  logic [LEN_BIT-1:0]  cmd_len,
    output logic                ram_en,
    output logic [ADDR_BIT-1:0] ram_addr,
    input  logic [WIDTH-1:0]    ram_dout,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_last,
    output logic                busy,
    output logic                done
);

    localparam int MAX_LEN = 1 << ADDR_BIT;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_BIT-1:0] base_q;
    logic [LEN_BIT-1:0]  len_q;
    logic [LEN_BIT-1:0]  issued_q;
    logic                inflight_q;
    logic                inflight_last_q;
    logic                idle_ready;
    logic                accept;
    logic                issue;
    logic                pop_now;
    logic                credit_ok;
    logic [2:0]          credit_sum;
    logic [1:0]          fifo_count;
    logic [WIDTH:0]      fifo_din;
    logic [WIDTH:0]      fifo_dout;

    // Words already committed to the FIFO: one in flight plus those stored,
    // minus the one leaving this cycle. A new read is allowed only if its
    // word will still find a free slot.
    always_comb begin
        credit_sum = {2'b00, inflight_q} + {1'b0, fifo_count} - {2'b00, pop_now};
        credit_ok  = (credit_sum <= 3'(FIFO_DEPTH - READ_LATENCY));
    end

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        idle_ready = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = (cmd_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (issued_q == len_q) begin
                    state_d = DRAIN;
                end else begin
                    issue = (issued_q < len_q) && credit_ok;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop_now && fifo_dout[WIDTH]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch and issued-read counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
        end else if (accept) begin
            base_q   <= cmd_base;
            len_q    <= cmd_len;
            issued_q <= '0;
        end else if (issue) begin
            issued_q <= issued_q + LEN_BIT'(1);
        end
    end

    // In-flight flag marks the cycle ram_dout carries a requested word; the
    // last flag travels with it so the FIFO can tag the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (issued_q == len_q - LEN_BIT'(1));
        end
    end

    assign fifo_din = {inflight_last_q, ram_dout};

    com_sync_fifo2 #(
        .W (WIDTH + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .pop   (pop_now),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign m_valid   = (fifo_count != 2'd0);
    assign pop_now   = m_valid && m_ready;
    assign m_data    = fifo_dout[WIDTH-1:0];
    assign m_last    = m_valid && fifo_dout[WIDTH];
    assign ram_en    = issue;
    assign ram_addr  = base_q + issued_q[ADDR_BIT-1:0];
    assign cmd_ready = idle_ready && rst_n;

    // A command longer than the address space is illegal.
    cmd_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (cmd_valid && cmd_ready) |-> (cmd_len <= LEN_BIT'(MAX_LEN)));

endmodule
